// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer
//   Multi-cycle execution sequencer between decode and the per-format ALU
//   units. It accepts one decoded instruction at a time, reads the register
//   file, drives operands and a unit start pulse, waits for multi-cycle units
//   and performs a single write-back per retired instruction.
//
//   Optional feature: define ALU_EXEC_TIMEOUT_EN to bound the WAIT state to
//   MAX_WAIT cycles (abort + sticky oERR on expiry). Without it, oERR is 0.
//
// Ports
//   iCLK, iRST_N              clock (rising edge), async active-low reset
//   iVALID / oREADY           decode handshake; accept on iVALID && oREADY
//   iUNIT, iMULTI             unit code and multi-cycle flag, captured on accept
//   iRD, iRS1, iRS2           register indices, captured on accept
//   oRF_RADDR1/2, iRF_RDATA1/2 register-file read port
//   oALU_IN1/2, oUNIT_SEL     operands and active unit code
//   oUNIT_START, oUNIT_ABORT  one-cycle unit control pulses
//   iUNIT_DONE, iALU_OUT      unit completion and result
//   oWB_EN/ADDR/DATA          register write-back
//   iFLUSH                    discard the in-flight instruction
//   oBUSY, oRETIRED, oERR     status
module alu_exec_sequencer #(
  parameter int unsigned UNIT_W   = 4,
  parameter int unsigned RET_W    = 32,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic [UNIT_W-1:0] iUNIT,
  input  logic              iMULTI,
  input  logic [4:0]        iRD,
  input  logic [4:0]        iRS1,
  input  logic [4:0]        iRS2,
  output logic [4:0]        oRF_RADDR1,
  output logic [4:0]        oRF_RADDR2,
  input  logic [31:0]       iRF_RDATA1,
  input  logic [31:0]       iRF_RDATA2,
  output logic [31:0]       oALU_IN1,
  output logic [31:0]       oALU_IN2,
  output logic [UNIT_W-1:0] oUNIT_SEL,
  output logic              oUNIT_START,
  input  logic              iUNIT_DONE,
  output logic              oUNIT_ABORT,
  input  logic [31:0]       iALU_OUT,
  output logic              oWB_EN,
  output logic [4:0]        oWB_ADDR,
  output logic [31:0]       oWB_DATA,
  input  logic              iFLUSH,
  output logic              oBUSY,
  output logic [RET_W-1:0]  oRETIRED,
  output logic              oERR
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("alu_exec_sequencer: MAX_WAIT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WAIT,
    S_WB
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                multi_q, multi_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          raddr1_q, raddr1_d;
  logic [4:0]          raddr2_q, raddr2_d;
  logic [31:0]         alu_in1_q, alu_in1_d;
  logic [31:0]         alu_in2_q, alu_in2_d;
  logic [UNIT_W-1:0]   sel_q, sel_d;
  logic                start_q, start_d;
  logic                abort_q, abort_d;
  logic                wb_en_q, wb_en_d;
  logic [4:0]          wb_addr_q, wb_addr_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [RET_W-1:0]    retired_q, retired_d;
  logic                err_q, err_d;

`ifdef ALU_EXEC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    multi_d   = multi_q;
    rd_d      = rd_q;
    raddr1_d  = raddr1_q;
    raddr2_d  = raddr2_q;
    alu_in1_d = alu_in1_q;
    alu_in2_d = alu_in2_q;
    sel_d     = sel_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    retired_d = retired_q;
    err_d     = err_q;
`ifdef ALU_EXEC_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A flush in IDLE only suppresses acceptance for that cycle.
        if (iVALID && ready_q && !iFLUSH) begin
          multi_d  = iMULTI;
          rd_d     = iRD;
          raddr1_d = iRS1;
          raddr2_d = iRS2;
          sel_d    = iUNIT;
          start_d  = 1'b1;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (iFLUSH) begin
          state_d = S_IDLE;
        end else begin
          alu_in1_d = iRF_RDATA1;
          alu_in2_d = iRF_RDATA2;
          state_d   = multi_q ? S_WAIT : S_EXEC;
`ifdef ALU_EXEC_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_EXEC: begin
        if (iFLUSH) begin
          state_d = S_IDLE;
        end else begin
          wb_data_d = iALU_OUT;
          wb_addr_d = rd_q;
          wb_en_d   = (rd_q != 5'd0);
          retired_d = retired_q + RET_W'(1);
          state_d   = S_WB;
        end
      end
      S_WAIT: begin
        // Flush has priority over a same-cycle completion.
        if (iFLUSH) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (iUNIT_DONE) begin
          wb_data_d = iALU_OUT;
          wb_addr_d = rd_q;
          wb_en_d   = (rd_q != 5'd0);
          retired_d = retired_q + RET_W'(1);
          state_d   = S_WB;
        end
`ifdef ALU_EXEC_TIMEOUT_EN
        // cnt_q counts completed WAIT cycles; this is the MAX_WAIT-th one.
        else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Write-back and retire are registered on WB entry, so the WB cycle
    // itself needs no further action and ignores iFLUSH.
    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      multi_q   <= 1'b0;
      rd_q      <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      sel_q     <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      multi_q   <= multi_d;
      rd_q      <= rd_d;
      raddr1_q  <= raddr1_d;
      raddr2_q  <= raddr2_d;
      alu_in1_q <= alu_in1_d;
      alu_in2_q <= alu_in2_d;
      sel_q     <= sel_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

`ifdef ALU_EXEC_TIMEOUT_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign oREADY      = ready_q;
  assign oBUSY       = busy_q;
  assign oRF_RADDR1  = raddr1_q;
  assign oRF_RADDR2  = raddr2_q;
  assign oALU_IN1    = alu_in1_q;
  assign oALU_IN2    = alu_in2_q;
  assign oUNIT_SEL   = sel_q;
  assign oUNIT_START = start_q;
  assign oUNIT_ABORT = abort_q;
  assign oWB_EN      = wb_en_q;
  assign oWB_ADDR    = wb_addr_q;
  assign oWB_DATA    = wb_data_q;
  assign oRETIRED    = retired_q;
  assign oERR        = err_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
module tb_alu_exec_sequencer;

  localparam int unsigned UNIT_W = 4;
  localparam int unsigned RET_W  = 32;
`ifdef ALU_EXEC_TIMEOUT_EN
  localparam int unsigned TB_MAX_WAIT = 4;
  localparam int unsigned MULTI_N     = 2;   // done inside the timeout window
`else
  localparam int unsigned TB_MAX_WAIT = 64;
  localparam int unsigned MULTI_N     = 10;  // done 10 cycles after start
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid = 1'b0;
  logic              ready;
  logic [UNIT_W-1:0] unit = '0;
  logic              multi = 1'b0;
  logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
  logic [4:0]        raddr1, raddr2;
  logic [31:0]       rdata1, rdata2;
  logic [31:0]       alu_in1, alu_in2;
  logic [UNIT_W-1:0] unit_sel;
  logic              start, abort, done = 1'b0;
  logic [31:0]       alu_out = '0;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  logic              flush = 1'b0;
  logic              busy;
  logic [RET_W-1:0]  retired;
  logic              err;

  logic [31:0] rf [32];

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;
  wb_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  alu_exec_sequencer #(
    .UNIT_W  (UNIT_W),
    .RET_W   (RET_W),
    .MAX_WAIT(TB_MAX_WAIT)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iVALID     (valid),
    .oREADY     (ready),
    .iUNIT      (unit),
    .iMULTI     (multi),
    .iRD        (rd),
    .iRS1       (rs1),
    .iRS2       (rs2),
    .oRF_RADDR1 (raddr1),
    .oRF_RADDR2 (raddr2),
    .iRF_RDATA1 (rdata1),
    .iRF_RDATA2 (rdata2),
    .oALU_IN1   (alu_in1),
    .oALU_IN2   (alu_in2),
    .oUNIT_SEL  (unit_sel),
    .oUNIT_START(start),
    .iUNIT_DONE (done),
    .oUNIT_ABORT(abort),
    .iALU_OUT   (alu_out),
    .oWB_EN     (wb_en),
    .oWB_ADDR   (wb_addr),
    .oWB_DATA   (wb_data),
    .iFLUSH     (flush),
    .oBUSY      (busy),
    .oRETIRED   (retired),
    .oERR       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write-back pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_en) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got addr %0d data 0x%0h, expected no write-back",
                 wb_addr, wb_data);
      end else begin
        wb_t e;
        e = sb.pop_front();
        if (wb_addr !== e.addr || wb_data !== e.data) begin
          n_fail++;
          $display("FAIL wb_match: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   wb_addr, wb_data, e.addr, e.data);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge (READ cycle).
  task automatic issue(input logic [UNIT_W-1:0] u, input logic m, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2);
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) check("issue_ready_timeout", 32'(ready), 32'd1);
    unit = u; multi = m; rd = d; rs1 = s1; rs2 = s2; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
    rf[1] = 32'h10;
    rf[2] = 32'h20;

    // Reset state
    #12;
    check("rst_ready",   32'(ready),   32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_wb_en",   32'(wb_en),   32'd0);
    check("rst_retired", retired,      32'd0);
    check("rst_alu_in1", alu_in1,      32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Single-cycle: start in READ, WB two cycles later, ready after that
    alu_out = 32'h30;
    sb.push_back('{addr: 5'd5, data: 32'h30});
    issue(4'd2, 1'b0, 5'd5, 5'd1, 5'd2);
    check("s_start",  32'(start),    32'd1);
    check("s_busy",   32'(busy),     32'd1);
    check("s_ready0", 32'(ready),    32'd0);
    check("s_raddr1", 32'(raddr1),   32'd1);
    check("s_sel",    32'(unit_sel), 32'd2);
    step();
    check("s_start_pulse", 32'(start), 32'd0);
    check("s_alu_in1", alu_in1, 32'h10);
    check("s_alu_in2", alu_in2, 32'h20);
    step();
    check("s_wb_en",   32'(wb_en), 32'd1);
    check("s_retired", retired,    32'd1);
    check("s_ready_wb", 32'(ready), 32'd0);
    step();
    check("s_ready_back", 32'(ready), 32'd1);
    check("s_wb_en_off",  32'(wb_en), 32'd0);

    // Multi-cycle: busy throughout, WB one cycle after done
    alu_out = 32'hDEADBEEF;
    sb.push_back('{addr: 5'd7, data: 32'hDEADBEEF});
    issue(4'd8, 1'b1, 5'd7, 5'd3, 5'd4);
    for (int i = 0; i < int'(MULTI_N); i++) begin
      step();
      check("m_busy", 32'(busy), 32'd1);
      check("m_no_wb", 32'(wb_en), 32'd0);
    end
    check("m_alu_in1", alu_in1, 32'h103);
    done = 1'b1;
    step();
    done = 1'b0;
    check("m_wb_en",   32'(wb_en), 32'd1);
    check("m_retired", retired,    32'd2);
    step();
    check("m_wb_single", 32'(wb_en), 32'd0);
    check("m_ready",     32'(ready), 32'd1);

    // rd == 0: no write-back but still retires
    alu_out = 32'h55;
    issue(4'd1, 1'b0, 5'd0, 5'd1, 5'd2);
    step(); step();
    check("z_wb_en",   32'(wb_en), 32'd0);
    check("z_retired", retired,    32'd3);
    step();
    check("z_ready", 32'(ready), 32'd1);

    // Flush in IDLE blocks acceptance
    valid = 1'b1; flush = 1'b1; rd = 5'd9;
    step();
    valid = 1'b0; flush = 1'b0;
    check("fi_ready", 32'(ready), 32'd1);
    check("fi_start", 32'(start), 32'd0);

    // Flush together with done in WAIT: abort, no WB, no retire
    issue(4'd8, 1'b1, 5'd11, 5'd1, 5'd2);
    step(); step();
    flush = 1'b1; done = 1'b1;
    step();
    flush = 1'b0; done = 1'b0;
    check("fw_abort",   32'(abort), 32'd1);
    check("fw_wb_en",   32'(wb_en), 32'd0);
    check("fw_ready",   32'(ready), 32'd1);
    check("fw_retired", retired,    32'd3);
    step();
    check("fw_abort_pulse", 32'(abort), 32'd0);

    // Asynchronous reset mid-WAIT
    issue(4'd9, 1'b1, 5'd12, 5'd1, 5'd2);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("ar_ready",   32'(ready),    32'd1);
    check("ar_busy",    32'(busy),     32'd0);
    check("ar_retired", retired,       32'd0);
    check("ar_alu_in1", alu_in1,       32'd0);
    check("ar_sel",     32'(unit_sel), 32'd0);
    check("ar_wb_data", wb_data,       32'd0);
    check("ar_raddr1",  32'(raddr1),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    alu_out = 32'h77;
    sb.push_back('{addr: 5'd3, data: 32'h77});
    issue(4'd3, 1'b0, 5'd3, 5'd2, 5'd1);
    step(); step();
    check("ar_next_wb",      32'(wb_en), 32'd1);
    check("ar_next_retired", retired,    32'd1);
    step();

`ifdef ALU_EXEC_TIMEOUT_EN
    // Timeout: abort and sticky error after MAX_WAIT WAIT cycles
    issue(4'd10, 1'b1, 5'd13, 5'd1, 5'd2);
    for (int i = 0; i < int'(TB_MAX_WAIT); i++) begin
      step();
      check("to_no_abort", 32'(abort), 32'd0);
    end
    step();
    check("to_abort",   32'(abort), 32'd1);
    check("to_err",     32'(err),   32'd1);
    check("to_ready",   32'(ready), 32'd1);
    check("to_retired", retired,    32'd1);
    alu_out = 32'h99;
    sb.push_back('{addr: 5'd4, data: 32'h99});
    issue(4'd1, 1'b0, 5'd4, 5'd1, 5'd2);
    step(); step(); step();
    check("to_err_sticky", 32'(err), 32'd1);
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
